// File: rtl/mem_acc_pkg.sv
// rtl/mem_acc_pkg.sv - request type codes, FSM state encoding and access sizing helpers
// Shared by mem_access_ctrl and mem_lane_merge; no ports.
package mem_acc_pkg;

   // req_type[1:0] size codes; req_type[UNSIGNED_BIT] selects zero-extension on loads
   localparam logic [1:0] TYPE_B       = 2'b00;
   localparam logic [1:0] TYPE_H       = 2'b01;
   localparam logic [1:0] TYPE_W       = 2'b10;
   localparam logic [1:0] TYPE_D       = 2'b11;
   localparam int         UNSIGNED_BIT = 2;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_RD_LO = 3'd1;
   localparam state_t S_RD_HI = 3'd2;
   localparam state_t S_CAP   = 3'd3;
   localparam state_t S_WR_LO = 3'd4;
   localparam state_t S_WR_HI = 3'd5;
   localparam state_t S_RESP  = 3'd6;

   function automatic logic [3:0] size_bytes(input logic [1:0] sz);
      logic [3:0] n;
      case (sz)
         TYPE_B:  n = 4'd1;
         TYPE_H:  n = 4'd2;
         TYPE_W:  n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   // True when an access of size sz starting at byte offset off spills past a nb-byte word
   function automatic logic crosses_word(input logic [3:0] off, input logic [1:0] sz, input int nb);
      logic [4:0] end_byte;
      end_byte = {1'b0, off} + {1'b0, size_bytes(sz)};
      return end_byte > 5'(nb);
   endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// rtl/mem_lane_merge.sv - byte-lane store merge and load extract/extend (combinational)
// Ports:
//   i_off       byte offset of the access inside the RAM word
//   i_size      size code (TYPE_B/H/W/D)
//   i_unsigned  zero-extend loads when set, sign-extend otherwise
//   i_hi_beat   selects the upper word of a word-crossing store
//   i_wdata     right-justified store data
//   i_old_word  word previously read from RAM, merged into by the store
//   i_lo_word   lower word of a load (word at the access address)
//   i_hi_word   upper word of a load (next word; ignored unless crossing)
//   o_wr_word   merged word to write for the selected beat
//   o_ld_data   extracted and extended load result
module mem_lane_merge
   import mem_acc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W/8)
)(
   input  logic [OFF_W-1:0]  i_off,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic              i_hi_beat,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_old_word,
   input  logic [DATA_W-1:0] i_lo_word,
   input  logic [DATA_W-1:0] i_hi_word,
   output logic [DATA_W-1:0] o_wr_word,
   output logic [DATA_W-1:0] o_ld_data
);

   localparam int NB = DATA_W/8;

   logic [2*NB-1:0]     w_size_mask;
   logic [2*NB-1:0]     w_lane_mask;
   logic [NB-1:0]       w_beat_mask;
   logic [2*DATA_W-1:0] w_st_wide;
   logic [DATA_W-1:0]   w_beat_data;
   logic [DATA_W-1:0]   w_ld_win;
   logic [OFF_W+2:0]    w_shift;

   assign w_shift = {i_off, 3'b000};

   always_comb begin
      w_size_mask = '0;
      case (i_size)
         TYPE_B:  w_size_mask[0]   = 1'b1;
         TYPE_H:  w_size_mask[1:0] = '1;
         TYPE_W:  w_size_mask[3:0] = '1;
         default: w_size_mask[7:0] = '1;
      endcase
   end

   // Stores are placed in a two-word window: the low beat owns the lower word,
   // the high beat the bytes that spilled into the next word.
   assign w_lane_mask = w_size_mask << i_off;
   assign w_st_wide   = {{DATA_W{1'b0}}, i_wdata} << w_shift;
   assign w_beat_mask = i_hi_beat ? w_lane_mask[2*NB-1:NB] : w_lane_mask[NB-1:0];
   assign w_beat_data = i_hi_beat ? w_st_wide[2*DATA_W-1:DATA_W] : w_st_wide[DATA_W-1:0];

   always_comb begin
      o_wr_word = i_old_word;
      for (int i = 0; i < NB; i++) begin
         if (w_beat_mask[i]) begin
            o_wr_word[i*8 +: 8] = w_beat_data[i*8 +: 8];
         end
      end
   end

   assign w_ld_win = DATA_W'({i_hi_word, i_lo_word} >> w_shift);

   always_comb begin
      o_ld_data = '0;
      case (i_size)
         TYPE_B:  o_ld_data = {{(DATA_W-8){~i_unsigned & w_ld_win[7]}}, w_ld_win[7:0]};
         TYPE_H:  o_ld_data = {{(DATA_W-16){~i_unsigned & w_ld_win[15]}}, w_ld_win[15:0]};
         TYPE_W:  o_ld_data[31:0] = w_ld_win[31:0];
         default: o_ld_data = w_ld_win;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store unit with read-modify-write and word-crossing split
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_*, o_req_ready    request handshake (we, type, byte addr, right-justified wdata)
//   o_rsp_valid/rdata/err   one-cycle completion pulse with registered load data
//   o_ram_addr/re/we/wdata  single-port RAM strobes (read data one cycle after o_ram_re)
//   i_ram_rdata             RAM read data
module mem_access_ctrl
   import mem_acc_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int RAM_AW      = 10,
   parameter bit MISALIGN_EN = 1'b1
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [2:0]        i_req_type,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_err,
   output logic [RAM_AW-1:0] o_ram_addr,
   output logic              o_ram_re,
   output logic              o_ram_we,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   localparam int NB    = DATA_W/8;
   localparam int OFF_W = $clog2(NB);

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [2:0]        r_type;
   logic [OFF_W-1:0]  r_off;
   logic [RAM_AW-1:0] r_word;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_lo_word;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_cross;
   logic              r_err;

   logic              w_accept;
   logic [OFF_W-1:0]  w_acc_off;
   logic [RAM_AW-1:0] w_acc_word;
   logic              w_acc_cross;
   logic              w_acc_err;
   logic              w_acc_full;
   logic [RAM_AW-1:0] w_word_hi;
   logic              w_re;
   logic              w_we;
   logic              w_hi_beat;
   logic [DATA_W-1:0] w_lo_src;
   logic [DATA_W-1:0] w_wr_word;
   logic [DATA_W-1:0] w_ld_data;

   assign w_accept    = i_req_valid && (r_state == S_IDLE);
   assign w_acc_off   = i_req_addr[OFF_W-1:0];
   assign w_acc_word  = RAM_AW'(i_req_addr >> OFF_W);
   assign w_acc_cross = crosses_word(4'(w_acc_off), i_req_type[1:0], NB);
   assign w_acc_err   = ((DATA_W == 32) && (i_req_type[1:0] == TYPE_D)) ||
                        (!MISALIGN_EN && w_acc_cross);
   // An aligned store covering every lane needs no read-back before the write
   assign w_acc_full  = i_req_we && (w_acc_off == '0) &&
                        (size_bytes(i_req_type[1:0]) == 4'(NB));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_acc_err)       w_next = S_RESP;
               else if (w_acc_full) w_next = S_WR_LO;
               else                 w_next = S_RD_LO;
            end
         end
         S_RD_LO: begin
            if (r_we)         w_next = S_WR_LO;
            else if (r_cross) w_next = S_RD_HI;
            else              w_next = S_CAP;
         end
         // RD_HI doubles as the high-word read of a crossing store
         S_RD_HI: w_next = r_we ? S_WR_HI : S_CAP;
         S_WR_LO: w_next = r_cross ? S_RD_HI : S_RESP;
         S_WR_HI: w_next = S_RESP;
         S_CAP:   w_next = S_RESP;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_type      <= '0;
         r_off       <= '0;
         r_word      <= '0;
         r_wdata     <= '0;
         r_lo_word   <= '0;
         r_rsp_rdata <= '0;
         r_cross     <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we    <= i_req_we;
            r_type  <= i_req_type;
            r_off   <= w_acc_off;
            r_word  <= w_acc_word;
            r_wdata <= i_req_wdata;
            r_cross <= w_acc_cross;
            r_err   <= w_acc_err;
         end
         // Low word of a crossing load arrives while the high word is being read
         if (r_state == S_RD_HI) begin
            r_lo_word <= i_ram_rdata;
         end
         if (w_next == S_RESP) begin
            r_rsp_rdata <= (r_state == S_CAP) ? w_ld_data : '0;
         end
      end
   end

   assign w_word_hi = r_word + RAM_AW'(1);
   assign w_hi_beat = (r_state == S_RD_HI) || (r_state == S_WR_HI);
   assign w_lo_src  = r_cross ? r_lo_word : i_ram_rdata;

   // Strobes drop in the same cycle reset is asserted
   assign w_re = !i_rst && ((r_state == S_RD_LO) || (r_state == S_RD_HI));
   assign w_we = !i_rst && ((r_state == S_WR_LO) || (r_state == S_WR_HI));

   mem_lane_merge #(
      .DATA_W (DATA_W),
      .OFF_W  (OFF_W)
   ) u_lane_merge (
      .i_off      (r_off),
      .i_size     (r_type[1:0]),
      .i_unsigned (r_type[UNSIGNED_BIT]),
      .i_hi_beat  (r_state == S_WR_HI),
      .i_wdata    (r_wdata),
      .i_old_word (i_ram_rdata),
      .i_lo_word  (w_lo_src),
      .i_hi_word  (i_ram_rdata),
      .o_wr_word  (w_wr_word),
      .o_ld_data  (w_ld_data)
   );

   assign o_req_ready = (r_state == S_IDLE);
   assign o_rsp_valid = (r_state == S_RESP);
   assign o_rsp_err   = (r_state == S_RESP) && r_err;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_ram_re    = w_re;
   assign o_ram_we    = w_we;
   assign o_ram_addr  = !(w_re || w_we) ? '0 : (w_hi_beat ? w_word_hi : r_word);
   assign o_ram_wdata = w_we ? w_wr_word : '0;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequential load/store unit that sits between the CPU memory stage and a single-port, non-byte-enabled synchronous data RAM.
- Handles byte, half, word and (optionally) double accesses by read-modify-write.
- Generalised in data width.
- Adds misaligned, word-crossing accesses, split into two RAM beats under an FSM with a valid/ready request handshake and a pulsed response.

Parameters:
- DATA_W, 32, RAM word width in bits; 32 or 64.
- ADDR_W, 32, byte-address width of req_addr.
- RAM_AW, 10, RAM word-address width.
- MISALIGN_EN, 1, 1 = split word-crossing accesses; 0 = flag them as errors.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  [2] = unsigned load, [1:0]: 00 byte, 01 half, 10 word, 11 double (DATA_W=64 only).
- req_addr  in  ADDR_W  byte address, little-endian.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; misaligned with MISALIGN_EN=0, or type 11 with DATA_W=32.
- ram_addr  out  RAM_AW  word address.
- ram_re  out  1  read strobe; data appears on ram_rdata the next cycle.
- ram_we  out  1  write strobe; full-word write.
- ram_wdata  out  DATA_W  merged write word.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset: state = IDLE. req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_re=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Accept: req_valid && req_ready at cycle T latches we, type, addr and wdata. req_ready drops at T+1.
- Addressing: size S = 1, 2, 4 or 8 bytes. off = addr mod (DATA_W/8). word = addr / (DATA_W/8), truncated to RAM_AW. crossing = off+S > DATA_W/8. The high beat uses word+1 and wraps modulo 2^RAM_AW.
- States: IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, RESP.
- Transitions:
  - IDLE -> RD_LO on accept, except an aligned full-word store, which goes IDLE -> WR_LO.
  - RD_LO -> RD_HI for a crossing load.
  - RD_LO -> CAP for a non-crossing load.
  - RD_LO -> WR_LO for a store.
  - RD_HI -> CAP.
  - WR_LO -> RD_HI_S for a crossing store. This reuses RD_HI with the store flag set; next state is WR_HI.
  - WR_LO -> RESP otherwise.
  - WR_HI -> RESP.
  - CAP -> RESP.
  - RESP -> IDLE.
- Latency, accept to rsp_valid:
  - aligned full-word store T+2;
  - non-crossing partial store T+3;
  - non-crossing load T+3;
  - crossing load T+4;
  - crossing store T+5.
- Error path: an error request goes IDLE -> RESP. rsp_valid=1 and rsp_err=1 at T+1. No RAM strobe is issued.
- Store merge: the WR beats replace only the addressed byte lanes of the previously read word and leave the other lanes bit-exact. The low beat takes the low-order bytes of wdata, the high beat the remainder.
- Load: CAP assembles the bytes (low beat captured in RD_HI, high beat from ram_rdata). Zero-extend when type[2]=1, otherwise sign-extend; word/double loads are not extended. The result is registered into rsp_rdata, valid only while rsp_valid=1 and held until the next response.
- Strobes: ram_re and ram_we are never high in the same cycle, and are never high in IDLE or RESP.
- No back-pressure on the response; the consumer must take rsp_valid when it pulses.
- A req_valid arriving while req_ready=0 is ignored. The requester holds it until accepted.
- Reset mid-operation: return to IDLE on the next edge and drop all strobes that cycle. For a crossing store interrupted after WR_LO, the low word stays written; this is defined behaviour.

Decomposition:
- Package mem_acc_pkg holds:
  - the req_type codes (TYPE_B, TYPE_H, TYPE_W, TYPE_D, UNSIGNED bit);
  - the state enum;
  - a size_bytes function;
  - a crosses_word function.
- One combinational sub-module, mem_lane_merge, does lane shift/merge for stores and lane extract plus sign/zero-extend for loads, parametrised by DATA_W. The FSM stays in mem_access_ctrl.

Test Plan:
- Byte store: DATA_W=32, RAM[1]=0xAABBCCDD, store byte addr 0x6 wdata 0x11 -> ram_we at T+2 with ram_addr=1, ram_wdata=0xAA11CCDD, rsp_valid at T+3.
- Signed half load: RAM[0]=0x8001F0FF, signed half load addr 0x2 -> rsp_rdata=0xFFFF8001 at T+3. Unsigned half load -> 0x00008001.
- Crossing word load: RAM[0]=0x44332211, RAM[1]=0x88776655, word load addr 0x3 -> two reads (addr 0 then 1), rsp_rdata=0x77665544 at T+4, rsp_err=0.
- Crossing half store: RAM[0]=0x00000000, RAM[1]=0xFFFFFFFF, store half addr 0x3 wdata 0xBEEF -> RAM[0]=0xEF000000, RAM[1]=0xFFFFFFBE, rsp_valid at T+5.
- MISALIGN_EN=0, word load addr 0x1 -> rsp_valid and rsp_err at T+1, rsp_rdata=0, no ram_re/ram_we observed.
- Reset mid-op: assert rst during RD_HI of a crossing store -> next cycle state IDLE, req_ready=1, all strobes 0. Then an aligned full-word store to addr 0x0 wdata 0x12345678 completes at T+2 with RAM[0]=0x12345678.
